// File: rtl/matmul_result_streamer.sv
// Output stage of the 2x2 matrix-multiplier core.
// Buffers up to two result frames (four signed accumulators each) and streams
// every frame out as four saturated OUT_W-bit beats, in push order.
// out_data/out_sat are combinational from the buffered frame only, so the
// core side can change c_data freely without disturbing a held beat.
module matmul_result_streamer #(
    parameter int ACC_W = 10,
    parameter int OUT_W = 8,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 c_valid,
    input  logic [4*ACC_W-1:0]   c_data,
    output logic                 c_ready,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [OUT_W-1:0]     out_data,
    output logic [1:0]           out_index,
    output logic                 out_last,
    output logic                 out_sat,
    output logic                 ovf_flag,
    input  logic                 clr_flags,
    output logic [7:0]           frame_cnt
);

    localparam int FRAME_W = 4 * ACC_W;
    // Saturation bounds expressed at accumulator width so comparisons stay signed
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (OUT_W - 1)));
    localparam logic [OUT_W-1:0] CLAMP_HI = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] CLAMP_LO = {1'b1, {(OUT_W - 1){1'b0}}};

    logic [FRAME_W-1:0] mem [DEPTH];

    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] idx_reg;
    logic       ovf_reg;
    logic [7:0] frame_cnt_reg;

    logic               push;
    logic               beat;
    logic               frame_done;
    logic [FRAME_W-1:0] rd_frame;
    logic [OUT_W-1:0]   elem_data [4];
    logic [3:0]         elem_sat;

    // Acceptance depends on the registered fill level only: a pop in the
    // same cycle does not free a slot until the following cycle.
    assign c_ready    = !rst && (count_reg != 2'(DEPTH));
    assign out_valid  = (count_reg != 2'd0);
    assign push       = c_valid && c_ready;
    assign beat       = out_valid && out_ready;
    assign frame_done = beat && (idx_reg == 2'd3);
    assign rd_frame   = mem[rd_ptr_reg];

    // Per-element saturation of the frame at the read pointer
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_elem
            logic signed [ACC_W-1:0] elem;
            logic                    above;
            logic                    below;
            assign elem  = rd_frame[gi*ACC_W +: ACC_W];
            assign above = (elem > SAT_MAX);
            assign below = (elem < SAT_MIN);
            assign elem_sat[gi]  = above || below;
            assign elem_data[gi] = above ? CLAMP_HI :
                                   below ? CLAMP_LO : elem[OUT_W-1:0];
        end
    endgenerate

    assign out_data  = out_valid ? elem_data[idx_reg] : '0;
    assign out_sat   = out_valid && elem_sat[idx_reg];
    assign out_index = idx_reg;
    assign out_last  = out_valid && (idx_reg == 2'd3);
    assign ovf_flag  = ovf_reg;
    assign frame_cnt = frame_cnt_reg;

    // Fill level: push and final-beat pop together leave it unchanged
    always_comb begin
        count_next = count_reg;
        case ({push, frame_done})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    // Control state: pointers, beat index, sticky overflow, frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg     <= 2'd0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            idx_reg       <= 2'd0;
            ovf_reg       <= 1'b0;
            frame_cnt_reg <= 8'd0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (beat) begin
                idx_reg <= idx_reg + 2'd1;
            end
            if (frame_done) begin
                rd_ptr_reg    <= ~rd_ptr_reg;
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end
            // A clamped beat leaving in the same cycle as a clear keeps the flag set
            if (beat && out_sat) begin
                ovf_reg <= 1'b1;
            end else if (clr_flags) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    // Frame storage; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= c_data;
        end
    end

endmodule

// File: tb/tb_matmul_result_streamer.sv
// Scoreboard bench for matmul_result_streamer: stimulus pushes hand-computed
// beats into a queue, a negedge monitor pops and compares transferred beats.
module tb_matmul_result_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_valid;
    logic [39:0] c_data;
    logic        c_ready;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_index;
    logic        out_last;
    logic        out_sat;
    logic        ovf_flag;
    logic        clr_flags;
    logic [7:0]  frame_cnt;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] i;
        logic       l;
        logic       s;
    } beat_t;

    beat_t sb[$];
    int checks = 0;
    int errors = 0;

    matmul_result_streamer #(.ACC_W(10), .OUT_W(8), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .c_valid   (c_valid),
        .c_data    (c_data),
        .c_ready   (c_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .out_sat   (out_sat),
        .ovf_flag  (ovf_flag),
        .clr_flags (clr_flags),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h at %0t", name, act, $time);
        end
    endtask

    function automatic logic [39:0] pk(input int a, input int b, input int c, input int d);
        return {10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    // Offer a frame until accepted; expected beats go to the scoreboard.
    // Returns 1 time unit after the accepting edge.
    task automatic push_frame(input logic [39:0] data, input logic [31:0] exp_b,
                              input logic [3:0] exp_s);
        bit done = 0;
        beat_t b;
        c_data  = data;
        c_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (c_ready) done = 1;
        end
        if (done) begin
            for (int k = 0; k < 4; k++) begin
                b.d = exp_b[k*8 +: 8];
                b.i = 2'(k);
                b.l = (k == 3);
                b.s = exp_s[k];
                sb.push_back(b);
            end
            @(posedge clk);
            #1;
        end else begin
            chk("push_timeout", 32'd0, 32'd1);
        end
        c_valid = 1'b0;
        c_data  = 40'h0;
    endtask

    // Wait until the scoreboard is empty and the DUT has gone idle
    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) done = 1;
        end
        chk("drain_idle", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare each transferred beat, idle outputs and held beats
    logic       hold_pending = 1'b0;
    logic [7:0] hold_data;
    logic [1:0] hold_index;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                chk("hold_stable", {22'd0, out_valid, out_index, out_data},
                    {22'd0, 1'b1, hold_index, hold_data});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", {22'd0, out_index, out_data}, 32'h3ff);
                end else begin
                    e = sb.pop_front();
                    chk("beat", {20'd0, out_data, out_index, out_last, out_sat},
                        {20'd0, e.d, e.i, e.l, e.s});
                end
            end else if (!out_valid) begin
                chk("idle_outputs", {22'd0, out_data, out_sat, out_last}, 32'd0);
            end
            hold_pending = out_valid && !out_ready;
            hold_data    = out_data;
            hold_index   = out_index;
        end
    end

    logic [15:0] pat;

    initial begin
        rst = 1'b1; c_valid = 1'b0; c_data = 40'h0; out_ready = 1'b0; clr_flags = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_c_ready", 32'(c_ready), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_ovf", 32'(ovf_flag), 32'd0);
        chk("rst_index_data", {22'd0, out_index, out_data}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("c_ready_after_rst", 32'(c_ready), 32'd1);

        // Plain frame, first-frame latency
        out_ready = 1'b1;
        push_frame(pk(4, -2, 0, 8), 32'h0800FE04, 4'b0000);
        chk("latency_valid", 32'(out_valid), 32'd1);
        drain();
        chk("frame_cnt_1", 32'(frame_cnt), 32'd1);

        // Saturation at both ends plus exact bounds
        push_frame(pk(300, -200, 127, -128), 32'h807F807F, 4'b0011);
        @(posedge clk);
        #1;
        chk("ovf_after_beat0", 32'(ovf_flag), 32'd1);
        drain();
        chk("frame_cnt_2", 32'(frame_cnt), 32'd2);
        clr_flags = 1'b1;
        @(posedge clk);
        #1;
        clr_flags = 1'b0;
        chk("ovf_cleared", 32'(ovf_flag), 32'd0);

        // Set wins over a simultaneous clear
        push_frame(pk(-129, 0, 0, 0), 32'h00000080, 4'b0001);
        clr_flags = 1'b1;
        @(posedge clk);
        #1;
        clr_flags = 1'b0;
        chk("ovf_set_wins", 32'(ovf_flag), 32'd1);
        drain();
        chk("frame_cnt_3", 32'(frame_cnt), 32'd3);

        // Fill both slots, third frame must be held off
        out_ready = 1'b0;
        push_frame(pk(1, 2, 3, 4), 32'h04030201, 4'b0000);
        push_frame(pk(5, 6, 7, 8), 32'h08070605, 4'b0000);
        chk("full_c_ready", 32'(c_ready), 32'd0);
        c_valid = 1'b1;
        c_data  = pk(9, 9, 9, 9);
        repeat (3) begin
            @(negedge clk);
            chk("full_hold_off", 32'(c_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        c_valid = 1'b0;
        out_ready = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            chk("c_ready_during_drain", 32'(c_ready), 32'(e == 4));
        end
        drain();
        chk("frame_cnt_5", 32'(frame_cnt), 32'd5);

        // Irregular out_ready pacing
        out_ready = 1'b0;
        push_frame(pk(-5, 100, -100, 50), 32'h329C64FB, 4'b0000);
        pat = 16'b1011_0011_0100_1001;
        for (int j = 0; j < 40 && (sb.size() != 0 || out_valid); j++) begin
            out_ready = pat[j % 16];
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();
        chk("frame_cnt_6", 32'(frame_cnt), 32'd6);

        // Push on the final beat of the only buffered frame
        push_frame(pk(10, 20, 30, 40), 32'h281E140A, 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_last_index", {30'd0, out_index}, 32'd3);
        push_frame(pk(-1, -2, 511, -512), 32'h807FFEFF, 4'b1100);
        chk("overlap_valid_idx", {29'd0, out_valid, out_index}, 32'h4);
        chk("overlap_count1", 32'(c_ready), 32'd1);
        drain();
        chk("frame_cnt_8", 32'(frame_cnt), 32'd8);

        // Asynchronous reset mid-frame with a second frame queued
        out_ready = 1'b0;
        push_frame(pk(11, 12, 13, 14), 32'h0E0D0C0B, 4'b0000);
        push_frame(pk(15, 16, 17, 18), 32'h1211100F, 4'b0000);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("mid_frame_index", {29'd0, out_valid, out_index}, 32'h6);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {30'd0, out_valid, c_ready}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("post_rst_idle", {30'd0, out_valid, c_ready}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push_frame(pk(7, -7, 1, -1), 32'hFF01F907, 4'b0000);
        chk("restart_index", {29'd0, out_valid, out_index}, 32'h4);
        drain();
        chk("frame_cnt_after_rst", 32'(frame_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_result_streamer.md
Name: matmul_result_streamer

Overview:
Downstream stage of the 2x2 matrix-multiplier core. Accepts one completed result matrix C (four signed accumulator values) per handshake and buffers up to two frames. Streams the frame out one saturated 8-bit element per beat on the user output byte. Decouples core completion from host read-out pacing and flags any element clamped to 8 bits.

Parameters:
ACC_W, 10, width of each signed accumulator element from the core
OUT_W, 8, width of each streamed signed output element (saturation target)
DEPTH, 2, frame buffer depth in frames (fixed at 2 for this revision)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
c_valid  input  1  core presents a complete result frame
c_data  input  4*ACC_W  frame: element k = c_data[k*ACC_W +: ACC_W], k=0 C00, 1 C01, 2 C10, 3 C11, two's complement
c_ready  output  1  streamer can accept a frame
out_ready  input  1  host consumes current beat
out_valid  output  1  out_data holds a valid element
out_data  output  OUT_W  saturated element, two's complement
out_index  output  2  element index k of current beat
out_last  output  1  current beat is element 3 of the frame
out_sat  output  1  current beat was clamped
ovf_flag  output  1  sticky: a clamped beat has been transferred
clr_flags  input  1  synchronous clear of ovf_flag
frame_cnt  output  8  frames fully streamed, wraps 255->0

Behaviour:
- One clock, clk; reset rst is asynchronous and active-high.
- Reset (async, immediate): count=0, wr_ptr=0, rd_ptr=0, idx=0, ovf_flag=0, frame_cnt=0. out_valid=0, out_data=0, out_index=0, out_last=0, out_sat=0. c_ready=0 while rst is high.
- Storage: 2-entry frame FIFO of 4*ACC_W registers. count in {0,1,2}.
- c_ready = !rst && (count != 2), derived from registered count only. A simultaneous pop does not open a slot in the same cycle.
- Push: c_valid && c_ready at edge -> mem[wr_ptr] <= c_data; wr_ptr toggles; count+1.
- out_valid = (count != 0). out_index = idx. out_last = out_valid && (idx == 3).
- out_data/out_sat are combinational from mem[rd_ptr] element idx only. There is no path from c_data. When out_valid=0, out_data=0 and out_sat=0.
- Saturation: value > 2^(OUT_W-1)-1 -> 0x7F, out_sat=1. Value < -2^(OUT_W-1) -> 0x80, out_sat=1. Otherwise truncate to OUT_W (sign preserved), out_sat=0.
- Beat transfer: out_valid && out_ready at edge -> idx+1.
  - If idx == 3: idx <= 0, rd_ptr toggles, count-1, frame_cnt+1 (mod 256).
  - Without out_ready: idx, out_data, out_index held stable.
- Simultaneous push and final-beat pop (count==1): count stays 1, both pointers advance.
- ovf_flag: set at edge of any transferred beat with out_sat=1. clr_flags clears it. If set and clear occur together, set wins.
- Latency: frame pushed at edge N -> out_valid=1 in cycle following N (count was 0). Minimum 4 cycles per frame with out_ready=1 held.
- Frames are streamed strictly in push order; no element reordering or skipping.
- rst asserted mid-frame: partially streamed and buffered frames are discarded. Streaming restarts at idx 0 on the next push.
- c_data may change while c_valid=0 or c_ready=0; only the value at the accepting edge is captured.

Test Plan:
- Reset, push {C00=4, C01=-2, C10=0, C11=8}, out_ready=1 -> beats 0x04, 0xFE, 0x00, 0x08; out_index 0..3; out_last only on 4th beat; frame_cnt=1; out_valid=0 after.
- Push {300, -200, 127, -128} -> 0x7F (sat=1), 0x80 (sat=1), 0x7F (sat=0), 0x80 (sat=0). ovf_flag=1 after beat 0. Pulse clr_flags -> 0.
- out_ready=0, push frames A then B -> c_ready=0 after B; third c_valid held off with no capture. Drain 4 beats -> c_ready=1 the cycle after A's last beat; B then streams intact.
- Toggle out_ready 1,0,0,1,... mid-frame -> out_data/out_index stable while out_ready=0; exactly 4 beats per frame, no duplicates.
- count=1 on A's last beat while pushing B in the same cycle -> B beat 0 valid next cycle; count stays 1.
- Assert rst during beat 2 of a frame, with a second frame queued -> out_valid=0 immediately (asynchronous). After release, count=0 and frame_cnt=0; next push streams from index 0.
